// File: rtl/resp_fifo_sync_if.sv
// Handshake/status bundle for resp_fifo_sync.
// master: the side that pushes/pops and observes status; slave: the FIFO itself.
// DATA_W and DEPTH must match the parameters of the resp_fifo_sync it connects to.
interface resp_fifo_sync_if #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 128
);
  localparam int AW = $clog2(DEPTH);

  logic              flush;
  logic [DATA_W-1:0] data_in;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [AW:0]       count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, data_in, write_en, read_en,
    input  data_out, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, data_in, write_en, read_en,
    output data_out, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/resp_fifo_sync.sv
// resp_fifo_sync: single-clock show-ahead response FIFO for the AXI-to-AHB bridge.
// Binary AW+1-bit pointers; occupancy, full/empty and almost_full derive only from
// registered pointers, so no status output has a combinational path from the inputs.
// flush clears the pointers synchronously and overrides any concurrent read/write.
// Optional feature: define RESP_FIFO_STATUS_EN to build sticky overflow/underflow
// flags; without it both ports are tied to 0 and no flops are built.
module resp_fifo_sync #(
  parameter int DATA_W   = 2,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic               clk,
  input logic               resetn,
  resp_fifo_sync_if.slave   bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);

  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_acc;
  logic        w_rd_acc;

  // Status from registered pointers only; the extra MSB tells full from empty.
  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Full gates writes with no look-ahead, so a pop in the same cycle does not free a slot.
  assign w_wr_acc = bus.write_en && !w_full  && !bus.flush;
  assign w_rd_acc = bus.read_en  && !w_empty && !bus.flush;

  // Pointer update: flush beats everything, otherwise advance on accepted transfers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (bus.flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; stale contents are never visible because data_out is gated by empty.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= bus.data_in;
  end

  assign bus.data_out    = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign bus.count       = w_count;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (w_count >= AF_THRESH);

`ifdef RESP_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky misuse flags; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.write_en && w_full  && !bus.flush) r_overflow  <= 1'b1;
      if (bus.read_en  && w_empty && !bus.flush) r_underflow <= 1'b1;
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_resp_fifo_sync.sv
// Testbench for resp_fifo_sync (DATA_W=2, DEPTH=8, AF_LEVEL=6).
// Reference model: a queue of words plus two sticky bits, updated from the
// behavioural rules each clock; every output is compared after every edge.
module tb_resp_fifo_sync;

  localparam int DATA_W   = 2;
  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  resp_fifo_sync_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  resp_fifo_sync #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  int max_cnt;
  bit saw_full;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic check_outputs(input string tag);
    int exp_dout;
    exp_dout = (q.size() == 0) ? 0 : q[0];
    check({tag, ".count"},       32'(bus.count),       q.size());
    check({tag, ".empty"},       32'(bus.empty),       (q.size() == 0) ? 1 : 0);
    check({tag, ".full"},        32'(bus.full),        (q.size() == DEPTH) ? 1 : 0);
    check({tag, ".almost_full"}, 32'(bus.almost_full), (q.size() >= AF_LEVEL) ? 1 : 0);
    check({tag, ".data_out"},    32'(bus.data_out),    exp_dout);
    check({tag, ".overflow"},    32'(bus.overflow),    32'(m_ovf));
    check({tag, ".underflow"},   32'(bus.underflow),   32'(m_udf));
  endtask

  // One clock of stimulus: drive, let the edge happen, update model, compare.
  task automatic step(input string tag, input bit wr, input bit rd, input bit fl, input int d);
    bit was_full;
    bit was_empty;
    int dummy;
    bus.write_en = wr;
    bus.read_en  = rd;
    bus.flush    = fl;
    bus.data_in  = DATA_W'(d);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (rd && !was_empty) dummy = q.pop_front();
      if (wr && !was_full)  q.push_back(d % 4);
    end
`ifdef RESP_FIFO_STATUS_EN
    if (!fl && wr && was_full)  m_ovf = 1'b1;
    if (!fl && rd && was_empty) m_udf = 1'b1;
`endif
    if (q.size() > max_cnt) max_cnt = q.size();
    if (q.size() == DEPTH)  saw_full = 1'b1;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.flush    = 1'b0;
    bus.data_in  = '0;
    #12;
    check_outputs("reset");
    @(negedge clk) resetn = 1'b1;

    // 1: reset asserted in the middle of a 3-write burst
    step("rst_burst", 1'b1, 1'b0, 1'b0, 1);
    step("rst_burst", 1'b1, 1'b0, 1'b0, 2);
    bus.write_en = 1'b1;
    bus.data_in  = 2'd3;
    @(negedge clk);
    #1 resetn = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1 check_outputs("rst_async");
    @(posedge clk);
    #1 check_outputs("rst_hold");
    @(negedge clk);
    resetn       = 1'b1;
    bus.write_en = 1'b0;
    step("rst_after", 1'b0, 1'b0, 1'b0, 0);

    // 2: fill, overfill attempt, drain
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 1'b0, i % 4);
    step("fill_9th", 1'b1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 1'b0, 0);
    step("drain_empty_rd", 1'b0, 1'b1, 1'b0, 0);

    // 3: pointer wrap with bursts of five
    max_cnt  = 0;
    saw_full = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) step("wrap_wr", 1'b1, 1'b0, 1'b0, i % 4);
      for (int i = 0; i < 5; i++) step("wrap_rd", 1'b0, 1'b1, 1'b0, 0);
    end
    check("wrap.max_count", 32'(max_cnt <= 5), 32'd1);
    check("wrap.never_full", 32'(saw_full), 32'd0);

    // 4: simultaneous read+write at full, empty and mid-level
    for (int i = 0; i < 8; i++) step("sim_fill", 1'b1, 1'b0, 1'b0, i % 4);
    step("sim_full", 1'b1, 1'b1, 1'b0, 3);
    step("sim_flush", 1'b0, 1'b0, 1'b1, 0);
    step("sim_empty", 1'b1, 1'b1, 1'b0, 3);
    for (int i = 0; i < 3; i++) step("sim_to4", 1'b1, 1'b0, 1'b0, i);
    step("sim_mid", 1'b1, 1'b1, 1'b0, 3);

    // 5: flush with a concurrent write
    step("fl_to5", 1'b1, 1'b0, 1'b0, 1);
    step("fl_wr", 1'b1, 1'b0, 1'b1, 2);
    step("fl_after", 1'b0, 1'b0, 1'b0, 0);

    // 6: misuse flags, then flush must not clear them
    for (int i = 0; i < 8; i++) step("st_fill", 1'b1, 1'b0, 1'b0, i % 4);
    step("st_ovf", 1'b1, 1'b0, 1'b0, 1);
    step("st_flush", 1'b0, 1'b0, 1'b1, 0);
    step("st_udf", 1'b0, 1'b1, 1'b0, 0);

    // Randomized traffic: write-heavy, then read-heavy, with occasional flushes
    for (int i = 0; i < 800; i++) begin
      int wr_pct;
      wr_pct = (i < 400) ? 70 : 35;
      step("rand",
           $urandom_range(0, 99) < wr_pct,
           $urandom_range(0, 99) < (100 - wr_pct),
           $urandom_range(0, 63) == 0,
           int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
